mmio_bus_arbiter: RTL

Two-requester arbiter and sequencer for the single shared data-memory/MMIO bus that drives m_addr, m_data and wea. The bus feeds RAM and the LED/peripheral window at 0x2000–0x201C.
- Port 0: tinyrv32 core.
- Port 1: debug loader/DMA engine.
The block registers the winning request onto the bus, waits for slave ready (with timeout), returns read data, and supports locked back-to-back sequences.

---
 rtl/mmio_bus_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter
//   Two-port arbiter/sequencer for the shared data-memory/MMIO bus
//   (RAM plus the LED/peripheral window at 0x2000-0x201C).
//   Port 0 is the tinyrv32 core, port 1 the debug loader/DMA engine.
//   A winning request is registered onto the bus. The block then waits
//   for m_ready, with a timeout, returns read data, and can hold
//   ownership across locked back-to-back sequences.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   reqN/weN/lockN           per-port request, write flag, lock hint
//   addrN/wdataN             per-port address and write data
//   gntN/doneN/errN          one-cycle pulses: captured/completed/timed out
//   rdata                    read data, valid with doneN for reads
//   m_addr/m_data/wea/m_re   shared bus drive
//   m_rdata/m_ready          shared bus slave response
module mmio_bus_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_data,
  output logic          wea,
  output logic          m_re,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_LOCKED
  } state_t;

  state_t        state, nxt_state;
  logic          owner, nxt_owner;
  logic          rr_last, nxt_rr_last;
  logic          lock_q, nxt_lock_q;
  logic [CW-1:0] cnt, nxt_cnt;

  logic          nxt_gnt0, nxt_gnt1;
  logic          nxt_done0, nxt_done1;
  logic          nxt_err0, nxt_err1;
  logic [DW-1:0] nxt_rdata;
  logic [AW-1:0] nxt_m_addr;
  logic [DW-1:0] nxt_m_data;
  logic          nxt_wea, nxt_m_re;

  logic          take;
  logic          win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      owner   <= 1'b0;
      rr_last <= 1'b1;
      lock_q  <= 1'b0;
      cnt     <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rdata   <= '0;
      m_addr  <= '0;
      m_data  <= '0;
      wea     <= 1'b0;
      m_re    <= 1'b0;
    end else begin
      state   <= nxt_state;
      owner   <= nxt_owner;
      rr_last <= nxt_rr_last;
      lock_q  <= nxt_lock_q;
      cnt     <= nxt_cnt;
      gnt0    <= nxt_gnt0;
      gnt1    <= nxt_gnt1;
      done0   <= nxt_done0;
      done1   <= nxt_done1;
      err0    <= nxt_err0;
      err1    <= nxt_err1;
      rdata   <= nxt_rdata;
      m_addr  <= nxt_m_addr;
      m_data  <= nxt_m_data;
      wea     <= nxt_wea;
      m_re    <= nxt_m_re;
    end
  end

  always_comb begin
    nxt_state   = state;
    nxt_owner   = owner;
    nxt_rr_last = rr_last;
    nxt_lock_q  = lock_q;
    nxt_cnt     = cnt;
    nxt_gnt0    = 1'b0;
    nxt_gnt1    = 1'b0;
    nxt_done0   = 1'b0;
    nxt_done1   = 1'b0;
    nxt_err0    = 1'b0;
    nxt_err1    = 1'b0;
    nxt_rdata   = rdata;
    nxt_m_addr  = m_addr;
    nxt_m_data  = m_data;
    nxt_wea     = 1'b0;
    nxt_m_re    = 1'b0;
    take        = 1'b0;
    win         = 1'b0;

    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          take = 1'b1;
          // On a tie the port that did not finish last wins.
          win  = (req0 && req1) ? ~rr_last : req1;
        end
      end

      S_XFER: begin
        if (m_ready) begin
          if (owner) nxt_done1 = 1'b1;
          else       nxt_done0 = 1'b1;
          if (!wea) nxt_rdata = m_rdata;
          nxt_rr_last = owner;
          nxt_state   = lock_q ? S_LOCKED : S_IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          // This edge is the TIMEOUT-th XFER cycle without m_ready.
          if (owner) nxt_err1 = 1'b1;
          else       nxt_err0 = 1'b1;
          nxt_rr_last = owner;
          nxt_lock_q  = 1'b0;
          nxt_state   = S_IDLE;
        end else begin
          nxt_cnt  = cnt + CW'(1);
          nxt_wea  = wea;
          nxt_m_re = m_re;
        end
      end

      S_LOCKED: begin
        // The non-owner port is invisible while the bus is locked.
        if (owner ? req1 : req0) begin
          take = 1'b1;
          win  = owner;
        end else if (!(owner ? lock1 : lock0)) begin
          nxt_state = S_IDLE;
        end
      end

      default: nxt_state = S_IDLE;
    endcase

    if (take) begin
      nxt_owner  = win;
      nxt_m_addr = win ? addr1 : addr0;
      nxt_m_data = win ? wdata1 : wdata0;
      nxt_wea    = win ? we1 : we0;
      nxt_m_re   = ~(win ? we1 : we0);
      nxt_lock_q = win ? lock1 : lock0;
      nxt_gnt0   = ~win;
      nxt_gnt1   = win;
      nxt_cnt    = '0;
      nxt_state  = S_XFER;
    end
  end

endmodule
